bram_stream_reader: RTL and testbench

- Parametrised successor to the per-run memory control unit. Streams a contiguous or strided block of words from CHANNELS independent read-only BRAM ports onto CHANNELS AXI-Stream masters.
- Uses a fixed-latency BRAM read model and a credit-limited per-channel skid FIFO, so backpressure never drops data.
- A single run FSM accepts start/size/base/stride, tracks per-channel tlast, and raises complete or error flags.
- Sits between the data/grid BRAMs and the KAN compute pipeline.

---
 rtl/bram_stream_reader.sv | 241 ++++++++++++++++++++++++
 tb/tb_bram_stream_reader.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// Streams a strided block of words from CHANNELS read-only BRAM ports onto AXI-Stream masters.
// Optional macro BRAM_STREAM_ABORT_EN adds operation_abort, which flushes a run into ERR.
module bram_stream_lane #(
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 10,
   parameter int COUNT_WIDTH  = 16,
   parameter int BRAM_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic                   run_i,
   input  logic                   flush_i,
   input  logic [ADDR_WIDTH-1:0]  base_i,
   input  logic [ADDR_WIDTH-1:0]  stride_i,
   input  logic [COUNT_WIDTH-1:0] size_i,
   output logic                   en_o,
   output logic [ADDR_WIDTH-1:0]  addr_o,
   input  logic [DATA_WIDTH-1:0]  rddata_i,
   output logic [DATA_WIDTH-1:0]  tdata_o,
   output logic                   tvalid_o,
   output logic                   tlast_o,
   input  logic                   tready_i,
   output logic                   done_o
);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CNW = PW + 1;
   localparam logic [CNW-1:0] DEPTH_C = CNW'(FIFO_DEPTH);

   typedef struct packed {
      logic                  last;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   entry_t                 mem_q [FIFO_DEPTH];
   entry_t                 head;
   logic [PW-1:0]          wr_q, rd_q;
   logic [CNW-1:0]         fcnt_q, fcnt_d, cred_q, cred_d;
   logic [COUNT_WIDTH-1:0] issued_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [BRAM_LATENCY:1]  vld_pipe_q, last_pipe_q;
   logic                   seen_q;
   logic                   push, pop, is_last;

   assign head     = mem_q[rd_q];
   assign tvalid_o = (fcnt_q != '0);
   assign pop      = tvalid_o & tready_i;
   assign push     = vld_pipe_q[BRAM_LATENCY];
   assign is_last  = (issued_q == size_i - COUNT_WIDTH'(1));
   // Credits cover in-flight reads plus FIFO entries; a pop this cycle frees one immediately.
   assign en_o     = run_i && (issued_q < size_i) && ((cred_q < DEPTH_C) || pop);
   assign addr_o   = addr_q;
   assign tdata_o  = tvalid_o ? head.data : '0;
   assign tlast_o  = tvalid_o & head.last;
   assign done_o   = seen_q | (pop & head.last);

   always_comb begin
      cred_d = cred_q;
      fcnt_d = fcnt_q;
      if (en_o && !pop)      cred_d = cred_q + CNW'(1);
      else if (!en_o && pop) cred_d = cred_q - CNW'(1);
      if (push && !pop)      fcnt_d = fcnt_q + CNW'(1);
      else if (!push && pop) fcnt_d = fcnt_q - CNW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         fcnt_q      <= '0;
         cred_q      <= '0;
         issued_q    <= '0;
         addr_q      <= '0;
         vld_pipe_q  <= '0;
         last_pipe_q <= '0;
         seen_q      <= 1'b0;
      end else if (flush_i) begin
         wr_q        <= '0;
         rd_q        <= '0;
         fcnt_q      <= '0;
         cred_q      <= '0;
         issued_q    <= '0;
         vld_pipe_q  <= '0;
         last_pipe_q <= '0;
         seen_q      <= 1'b0;
      end else begin
         if (start_i) begin
            addr_q   <= base_i;
            issued_q <= '0;
            seen_q   <= 1'b0;
         end else if (en_o) begin
            addr_q   <= addr_q + stride_i;
            issued_q <= issued_q + COUNT_WIDTH'(1);
         end
         vld_pipe_q[1]  <= en_o;
         last_pipe_q[1] <= en_o & is_last;
         for (int i = 2; i <= BRAM_LATENCY; i++) begin
            vld_pipe_q[i]  <= vld_pipe_q[i-1];
            last_pipe_q[i] <= last_pipe_q[i-1];
         end
         if (push) begin
            mem_q[wr_q] <= '{last: last_pipe_q[BRAM_LATENCY], data: rddata_i};
            wr_q        <= wr_q + PW'(1);
         end
         if (pop) begin
            rd_q <= rd_q + PW'(1);
            if (head.last) seen_q <= 1'b1;
         end
         fcnt_q <= fcnt_d;
         cred_q <= cred_d;
      end
   end
endmodule

module bram_stream_reader #(
   parameter int CHANNELS     = 1,
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 10,
   parameter int COUNT_WIDTH  = 16,
   parameter int BRAM_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           operation_start,
`ifdef BRAM_STREAM_ABORT_EN
   input  logic                           operation_abort,
`endif
   input  logic [ADDR_WIDTH-1:0]          base_addr,
   input  logic [ADDR_WIDTH-1:0]          stride,
   input  logic [COUNT_WIDTH-1:0]         run_size,
   output logic [CHANNELS-1:0]            bram_en,
   output logic [CHANNELS*ADDR_WIDTH-1:0] bram_addr,
   input  logic [CHANNELS*DATA_WIDTH-1:0] bram_rddata,
   output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
   output logic [CHANNELS-1:0]            m_axis_tvalid,
   input  logic [CHANNELS-1:0]            m_axis_tready,
   output logic [CHANNELS-1:0]            m_axis_tlast,
   output logic                           operation_in_progress,
   output logic                           operation_complete,
   output logic                           operation_error
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

   state_t                                state_q;
   logic [COUNT_WIDTH-1:0]                size_q;
   logic [ADDR_WIDTH-1:0]                 stride_q;
   logic                                  busy_q, cmpl_q, err_q;
   logic                                  abort, start_ok, lane_run, flush;
   logic [CHANNELS-1:0]                   lane_done;
   logic [CHANNELS-1:0][ADDR_WIDTH-1:0]   addr_a;
   logic [CHANNELS-1:0][DATA_WIDTH-1:0]   rd_a, td_a;

`ifdef BRAM_STREAM_ABORT_EN
   assign abort = operation_abort;
`else
   assign abort = 1'b0;
`endif

   assign start_ok = (state_q == S_IDLE) && operation_start && (run_size != '0);
   assign lane_run = (state_q == S_RUN) && !abort;
   assign flush    = (state_q == S_RUN) && abort;

   assign rd_a                  = bram_rddata;
   assign bram_addr             = addr_a;
   assign m_axis_tdata          = td_a;
   assign operation_in_progress = busy_q;
   assign operation_complete    = cmpl_q;
   assign operation_error       = err_q;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      bram_stream_lane #(
         .DATA_WIDTH  (DATA_WIDTH),
         .ADDR_WIDTH  (ADDR_WIDTH),
         .COUNT_WIDTH (COUNT_WIDTH),
         .BRAM_LATENCY(BRAM_LATENCY),
         .FIFO_DEPTH  (FIFO_DEPTH)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .start_i (start_ok),
         .run_i   (lane_run),
         .flush_i (flush),
         .base_i  (base_addr),
         .stride_i(stride_q),
         .size_i  (size_q),
         .en_o    (bram_en[g]),
         .addr_o  (addr_a[g]),
         .rddata_i(rd_a[g]),
         .tdata_o (td_a[g]),
         .tvalid_o(m_axis_tvalid[g]),
         .tlast_o (m_axis_tlast[g]),
         .tready_i(m_axis_tready[g]),
         .done_o  (lane_done[g])
      );
   end

   // lane_done includes a tlast handshake happening now, so DONE follows the last transfer directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         size_q   <= '0;
         stride_q <= '0;
         busy_q   <= 1'b0;
         cmpl_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         cmpl_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (operation_start) begin
                  if (run_size != '0) begin
                     state_q  <= S_RUN;
                     busy_q   <= 1'b1;
                     size_q   <= run_size;
                     stride_q <= stride;
                  end else begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (abort) begin
                  state_q <= S_ERR;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
               end else if (&lane_done) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  cmpl_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomised self-checking bench for bram_stream_reader (2 lanes, latency 2, depth 4).
module tb_bram_stream_reader;
   localparam int CH = 2, DW = 16, AW = 10, CW = 16, L = 2, D = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                operation_start;
`ifdef BRAM_STREAM_ABORT_EN
   logic                operation_abort;
`endif
   logic [AW-1:0]       base_addr, stride;
   logic [CW-1:0]       run_size;
   logic [CH-1:0]       bram_en;
   logic [CH*AW-1:0]    bram_addr;
   logic [CH*DW-1:0]    bram_rddata;
   logic [CH*DW-1:0]    m_axis_tdata;
   logic [CH-1:0]       m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic                operation_in_progress, operation_complete, operation_error;

   int tests = 0, fails = 0;
   int cyc = 0;
   int s_cyc;

   bram_stream_reader #(
      .CHANNELS(CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .COUNT_WIDTH(CW), .BRAM_LATENCY(L), .FIFO_DEPTH(D)
   ) dut (
      .clk(clk), .rst(rst), .operation_start(operation_start),
`ifdef BRAM_STREAM_ABORT_EN
      .operation_abort(operation_abort),
`endif
      .base_addr(base_addr), .stride(stride), .run_size(run_size),
      .bram_en(bram_en), .bram_addr(bram_addr), .bram_rddata(bram_rddata),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .operation_in_progress(operation_in_progress),
      .operation_complete(operation_complete), .operation_error(operation_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // BRAM model: data = address ^ per-lane salt, exactly L cycles after the enable.
   logic [DW-1:0] salt [CH];
   logic [AW-1:0] bp [CH][L];
   logic          bv [CH][L];
   always @(posedge clk) begin
      for (int l = 0; l < CH; l++) begin
         bp[l][0] <= bram_addr[l*AW +: AW];
         bv[l][0] <= bram_en[l];
         for (int i = 1; i < L; i++) begin
            bp[l][i] <= bp[l][i-1];
            bv[l][i] <= bv[l][i-1];
         end
      end
   end
   for (genvar g = 0; g < CH; g++) begin : g_bram
      assign bram_rddata[g*DW +: DW] = bv[g][L-1] ? (DW'(bp[g][L-1]) ^ salt[g]) : 16'hDEAD;
   end

   // Passive monitor: records every issue, transfer and status pulse.
   logic [DW:0]   obs_q   [CH][$];
   int            obs_cyc [CH][$];
   logic [AW-1:0] iss_q   [CH][$];
   int            outst [CH] = '{default: 0};
   int            n_cmpl = 0, n_err = 0, cmpl_cyc = 0;
   always @(negedge clk) begin
      for (int l = 0; l < CH; l++) begin
         if (bram_en[l]) iss_q[l].push_back(bram_addr[l*AW +: AW]);
         if (m_axis_tvalid[l] && m_axis_tready[l]) begin
            obs_q[l].push_back({m_axis_tlast[l], m_axis_tdata[l*DW +: DW]});
            obs_cyc[l].push_back(cyc);
         end
         if (rst) outst[l] <= 0;
         else outst[l] <= outst[l] + (bram_en[l] ? 1 : 0)
                          - ((m_axis_tvalid[l] && m_axis_tready[l]) ? 1 : 0);
      end
      if (operation_complete) begin
         n_cmpl   <= n_cmpl + 1;
         cmpl_cyc <= cyc;
      end
      if (operation_error) n_err <= n_err + 1;
   end

   // Reference: element k of a run is read from (base + k*stride) mod 2^AW, tlast on k == n-1.
   function automatic logic [DW:0] expw(input int l, input int b, input int s, input int k, input int n);
      int t;
      logic [AW-1:0] a;
      t = b + k * s;
      a = t[AW-1:0];
      return {(k == n - 1), DW'(a) ^ salt[l]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int b, input int s, input int n);
      base_addr       = AW'(b);
      stride          = AW'(s);
      run_size        = CW'(n);
      operation_start = 1'b1;
      s_cyc           = cyc;
      tick();
      operation_start = 1'b0;
   endtask

   task automatic wait_end(input int budget, input int pct, input bit jam, output bit to);
      bit seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         for (int l = 0; l < CH; l++) m_axis_tready[l] = ($urandom_range(0, 99) < pct);
         if (jam && operation_in_progress) begin
            operation_start = 1'($urandom_range(0, 1));
            base_addr       = AW'($urandom);
            stride          = AW'($urandom);
            run_size        = CW'($urandom_range(0, 30));
         end else operation_start = 1'b0;
         tick();
         seen = operation_complete || operation_error;
      end
      operation_start = 1'b0;
      m_axis_tready   = '1;
      to = !seen;
      if (seen) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      operation_start = 1'b0;
`ifdef BRAM_STREAM_ABORT_EN
      operation_abort = 1'b0;
`endif
      base_addr = '0; stride = '0; run_size = '0;
      m_axis_tready = '1;
      salt[0] = '0; salt[1] = '0;
      tick(); tick();
      for (int p = 0; p < 2; p++) begin
         tests++; if (bram_en !== '0) begin fails++; $display("FAIL reset_en p%0d: got %h want 0", p, bram_en); end
         tests++; if (bram_addr !== '0) begin fails++; $display("FAIL reset_addr p%0d: got %h want 0", p, bram_addr); end
         tests++; if (m_axis_tdata !== '0) begin fails++; $display("FAIL reset_tdata p%0d: got %h want 0", p, m_axis_tdata); end
         tests++; if ({m_axis_tvalid, m_axis_tlast} !== '0) begin fails++; $display("FAIL reset_vl p%0d: got %b want 0", p, {m_axis_tvalid, m_axis_tlast}); end
         tests++; if ({operation_in_progress, operation_complete, operation_error} !== 3'b000) begin
            fails++; $display("FAIL reset_status p%0d: got %b want 000", p, {operation_in_progress, operation_complete, operation_error}); end
         rst = 1'b0;
         tick();
      end
   endtask

   task automatic test_basic_stream();
      int ob[CH], ib[CH], c0, last_hs;
      bit to;
      salt[0] = 16'h0000; salt[1] = 16'h8000;
      for (int l = 0; l < CH; l++) begin ob[l] = obs_q[l].size(); ib[l] = iss_q[l].size(); end
      c0 = n_cmpl;
      start(16'h10, 1, 4);
      tests++; if (operation_in_progress !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b want 1", operation_in_progress); end
      wait_end(100, 100, 1'b0, to);
      tests++; if (to) begin fails++; $display("FAIL basic_timeout: got timeout want complete"); end
      last_hs = 0;
      for (int l = 0; l < CH; l++) begin
         tests++; if (obs_q[l].size() - ob[l] !== 4) begin fails++; $display("FAIL basic_count lane%0d: got %0d want 4", l, obs_q[l].size() - ob[l]); end
         for (int k = 0; k < 4 && ob[l] + k < obs_q[l].size(); k++) begin
            tests++; if (obs_q[l][ob[l]+k] !== expw(l, 16'h10, 1, k, 4)) begin
               fails++; $display("FAIL basic_word lane%0d k%0d: got %h want %h", l, k, obs_q[l][ob[l]+k], expw(l, 16'h10, 1, k, 4)); end
            tests++; if (obs_cyc[l][ob[l]+k] !== s_cyc + 2 + L + k) begin
               fails++; $display("FAIL basic_timing lane%0d k%0d: got cycle %0d want %0d", l, k, obs_cyc[l][ob[l]+k], s_cyc + 2 + L + k); end
            if (obs_cyc[l][ob[l]+k] > last_hs) last_hs = obs_cyc[l][ob[l]+k];
         end
         for (int k = 0; k < 4 && ib[l] + k < iss_q[l].size(); k++) begin
            tests++; if (iss_q[l][ib[l]+k] !== AW'(16'h10 + k)) begin
               fails++; $display("FAIL basic_addr lane%0d k%0d: got %h want %h", l, k, iss_q[l][ib[l]+k], AW'(16'h10 + k)); end
         end
      end
      tests++; if (n_cmpl - c0 !== 1) begin fails++; $display("FAIL basic_cmpl_count: got %0d want 1", n_cmpl - c0); end
      tests++; if (cmpl_cyc !== last_hs + 1) begin fails++; $display("FAIL basic_cmpl_cycle: got %0d want %0d", cmpl_cyc, last_hs + 1); end
   endtask

   task automatic test_zero_size();
      int ob[CH], ib[CH], e0;
      bit to;
      for (int l = 0; l < CH; l++) ib[l] = iss_q[l].size();
      e0 = n_err;
      start(16'h55, 1, 0);
      tests++; if ({operation_error, operation_in_progress} !== 2'b10) begin
         fails++; $display("FAIL zero_err_pulse: got err,busy=%b want 10", {operation_error, operation_in_progress}); end
      tick();
      tests++; if (operation_error !== 1'b0) begin fails++; $display("FAIL zero_err_width: got %b want 0", operation_error); end
      tick();
      tests++; if (n_err - e0 !== 1) begin fails++; $display("FAIL zero_err_count: got %0d want 1", n_err - e0); end
      for (int l = 0; l < CH; l++) begin
         tests++; if (iss_q[l].size() !== ib[l]) begin fails++; $display("FAIL zero_no_issue lane%0d: got %0d want %0d", l, iss_q[l].size(), ib[l]); end
         ob[l] = obs_q[l].size();
      end
      start(16'h20, 2, 3);
      wait_end(100, 100, 1'b0, to);
      tests++; if (to) begin fails++; $display("FAIL zero_next_timeout: got timeout want complete"); end
      for (int l = 0; l < CH; l++) begin
         tests++; if (obs_q[l].size() - ob[l] !== 3) begin fails++; $display("FAIL zero_next_count lane%0d: got %0d want 3", l, obs_q[l].size() - ob[l]); end
         for (int k = 0; k < 3 && ob[l] + k < obs_q[l].size(); k++) begin
            tests++; if (obs_q[l][ob[l]+k] !== expw(l, 16'h20, 2, k, 3)) begin
               fails++; $display("FAIL zero_next_word lane%0d k%0d: got %h want %h", l, k, obs_q[l][ob[l]+k], expw(l, 16'h20, 2, k, 3)); end
         end
      end
   endtask

   task automatic test_backpressure();
      int ob[CH], b, hold, mx;
      bit held, done;
      salt[0] = 16'($urandom); salt[1] = 16'($urandom);
      b = $urandom_range(0, 1023);
      for (int l = 0; l < CH; l++) ob[l] = obs_q[l].size();
      hold = 0; mx = 0; held = 1'b0; done = 1'b0;
      m_axis_tready = '1;
      start(b, 1, 16);
      for (int c = 0; c < 200 && !done; c++) begin
         if (!held && obs_q[0].size() - ob[0] >= 3) begin held = 1'b1; hold = 10; end
         m_axis_tready[0] = (hold == 0);
         if (hold > 0) hold--;
         tick();
         if (held && outst[0] > mx) mx = outst[0];
         done = operation_complete;
      end
      m_axis_tready = '1;
      tick();
      tests++; if (!done) begin fails++; $display("FAIL bp_timeout: got timeout want complete"); end
      tests++; if (mx !== D) begin fails++; $display("FAIL bp_outstanding: got max %0d want %0d", mx, D); end
      for (int l = 0; l < CH; l++) begin
         tests++; if (obs_q[l].size() - ob[l] !== 16) begin fails++; $display("FAIL bp_count lane%0d: got %0d want 16", l, obs_q[l].size() - ob[l]); end
         for (int k = 0; k < 16 && ob[l] + k < obs_q[l].size(); k++) begin
            tests++; if (obs_q[l][ob[l]+k] !== expw(l, b, 1, k, 16)) begin
               fails++; $display("FAIL bp_word lane%0d k%0d: got %h want %h", l, k, obs_q[l][ob[l]+k], expw(l, b, 1, k, 16)); end
         end
      end
      for (int k = 1; k < 16 && ob[1] + k < obs_cyc[1].size(); k++) begin
         tests++; if (obs_cyc[1][ob[1]+k] !== obs_cyc[1][ob[1]] + k) begin
            fails++; $display("FAIL bp_lane1_rate k%0d: got cycle %0d want %0d", k, obs_cyc[1][ob[1]+k], obs_cyc[1][ob[1]] + k); end
      end
   endtask

   task automatic test_addr_wrap();
      int ib[CH];
      logic [AW-1:0] wa [3];
      bit to;
      wa[0] = 10'h3FE; wa[1] = 10'h001; wa[2] = 10'h004;
      for (int l = 0; l < CH; l++) ib[l] = iss_q[l].size();
      start(10'h3FE, 3, 3);
      wait_end(100, 100, 1'b0, to);
      tests++; if (to) begin fails++; $display("FAIL wrap_timeout: got timeout want complete"); end
      for (int l = 0; l < CH; l++) begin
         tests++; if (iss_q[l].size() - ib[l] !== 3) begin fails++; $display("FAIL wrap_issue_count lane%0d: got %0d want 3", l, iss_q[l].size() - ib[l]); end
         for (int k = 0; k < 3 && ib[l] + k < iss_q[l].size(); k++) begin
            tests++; if (iss_q[l][ib[l]+k] !== wa[k]) begin
               fails++; $display("FAIL wrap_addr lane%0d k%0d: got %h want %h", l, k, iss_q[l][ib[l]+k], wa[k]); end
         end
      end
   endtask

   task automatic test_reset_midrun();
      int ob[CH], ib[CH], b, s;
      bit to;
      salt[0] = 16'($urandom); salt[1] = 16'($urandom);
      start($urandom_range(0, 1023), 1, 8);
      tick(); tick();
      rst = 1'b1;
      tick();
      tests++; if ({bram_en, bram_addr, m_axis_tdata} !== '0) begin
         fails++; $display("FAIL rst_mid_bus: got %h want 0", {bram_en, bram_addr, m_axis_tdata}); end
      tests++; if ({m_axis_tvalid, m_axis_tlast, operation_in_progress, operation_complete, operation_error} !== '0) begin
         fails++; $display("FAIL rst_mid_ctrl: got %b want 0", {m_axis_tvalid, m_axis_tlast, operation_in_progress, operation_complete, operation_error}); end
      rst = 1'b0;
      tick();
      salt[0] = 16'($urandom); salt[1] = 16'($urandom);
      for (int l = 0; l < CH; l++) begin ob[l] = obs_q[l].size(); ib[l] = iss_q[l].size(); end
      b = $urandom_range(0, 1023); s = $urandom_range(0, 1023);
      start(b, s, 2);
      wait_end(100, 100, 1'b0, to);
      tests++; if (to) begin fails++; $display("FAIL rst_next_timeout: got timeout want complete"); end
      for (int l = 0; l < CH; l++) begin
         tests++; if (obs_q[l].size() - ob[l] !== 2) begin fails++; $display("FAIL rst_next_count lane%0d: got %0d want 2", l, obs_q[l].size() - ob[l]); end
         tests++; if (iss_q[l].size() - ib[l] !== 2) begin fails++; $display("FAIL rst_next_issue lane%0d: got %0d want 2", l, iss_q[l].size() - ib[l]); end
         for (int k = 0; k < 2 && ob[l] + k < obs_q[l].size(); k++) begin
            tests++; if (obs_q[l][ob[l]+k] !== expw(l, b, s, k, 2)) begin
               fails++; $display("FAIL rst_next_word lane%0d k%0d: got %h want %h", l, k, obs_q[l][ob[l]+k], expw(l, b, s, k, 2)); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int ob[CH], b, s, n, c0, e0;
      bit to;
      for (int r = 0; r < 6; r++) begin
         salt[0] = 16'($urandom); salt[1] = 16'($urandom);
         b = $urandom_range(0, 1023); s = $urandom_range(0, 1023); n = $urandom_range(1, 24);
         for (int l = 0; l < CH; l++) ob[l] = obs_q[l].size();
         c0 = n_cmpl; e0 = n_err;
         start(b, s, n);
         wait_end(600, 60, 1'b1, to);
         tick();
         tests++; if (to) begin fails++; $display("FAIL b2b_timeout r%0d: got timeout want complete", r); end
         tests++; if ({n_cmpl - c0, n_err - e0} !== {32'd1, 32'd0}) begin
            fails++; $display("FAIL b2b_status r%0d: got cmpl %0d err %0d want 1 0", r, n_cmpl - c0, n_err - e0); end
         for (int l = 0; l < CH; l++) begin
            tests++; if (obs_q[l].size() - ob[l] !== n) begin fails++; $display("FAIL b2b_count r%0d lane%0d: got %0d want %0d", r, l, obs_q[l].size() - ob[l], n); end
            for (int k = 0; k < n && ob[l] + k < obs_q[l].size(); k++) begin
               tests++; if (obs_q[l][ob[l]+k] !== expw(l, b, s, k, n)) begin
                  fails++; $display("FAIL b2b_word r%0d lane%0d k%0d: got %h want %h", r, l, k, obs_q[l][ob[l]+k], expw(l, b, s, k, n)); end
            end
         end
      end
   endtask

`ifdef BRAM_STREAM_ABORT_EN
   task automatic test_abort();
      int ob[CH], b, c0, e0;
      bit hit;
      salt[0] = 16'($urandom); salt[1] = 16'($urandom);
      b = $urandom_range(0, 1023);
      for (int l = 0; l < CH; l++) ob[l] = obs_q[l].size();
      c0 = n_cmpl; e0 = n_err; hit = 1'b0;
      m_axis_tready = '1;
      start(b, 1, 6);
      for (int c = 0; c < 50 && !hit; c++) begin
         if (obs_q[0].size() - ob[0] == 1 && m_axis_tvalid[0]) hit = 1'b1;
         else tick();
      end
      tests++; if (!hit) begin fails++; $display("FAIL abort_no_second_transfer: got timeout want transfer"); end
      operation_abort = 1'b1;
      tick();
      operation_abort = 1'b0;
      tests++; if ({m_axis_tvalid, operation_error} !== 3'b001) begin
         fails++; $display("FAIL abort_next: got tvalid,err=%b want 001", {m_axis_tvalid, operation_error}); end
      for (int c = 0; c < 8; c++) tick();
      tests++; if ({n_cmpl - c0, n_err - e0} !== {32'd0, 32'd1}) begin
         fails++; $display("FAIL abort_status: got cmpl %0d err %0d want 0 1", n_cmpl - c0, n_err - e0); end
      tests++; if (obs_q[0].size() - ob[0] !== 2) begin fails++; $display("FAIL abort_count: got %0d want 2", obs_q[0].size() - ob[0]); end
      for (int l = 0; l < CH; l++) begin
         for (int k = 0; ob[l] + k < obs_q[l].size(); k++) begin
            tests++; if (obs_q[l][ob[l]+k] !== expw(l, b, 1, k, 1000)) begin
               fails++; $display("FAIL abort_word lane%0d k%0d: got %h want %h (no tlast)", l, k, obs_q[l][ob[l]+k], expw(l, b, 1, k, 1000)); end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_stream();
      test_zero_size();
      test_backpressure();
      test_addr_wrap();
      test_reset_midrun();
      test_back_to_back();
`ifdef BRAM_STREAM_ABORT_EN
      test_abort();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end
endmodule
